// File: rtl/usb_sched_pkg.sv
// rtl/usb_sched_pkg.sv - shared types for the USB interrupt-IN poll scheduler
//
// Contents: transaction type, engine result codes, scheduler FSM states.

package usb_sched_pkg;

    typedef enum logic {
        TXN_SOF = 1'b0,
        TXN_IN  = 1'b1
    } txn_type_e;

    // Codes 6 and 7 are not defined by the packet engine; they are handled as TIMEOUT.
    typedef enum logic [2:0] {
        RES_DATA0   = 3'd0,
        RES_DATA1   = 3'd1,
        RES_NAK     = 3'd2,
        RES_STALL   = 3'd3,
        RES_TIMEOUT = 3'd4,
        RES_CRC_ERR = 3'd5
    } txn_result_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT     = 3'd1,
        ST_SOF_REQ  = 3'd2,
        ST_SOF_WAIT = 3'd3,
        ST_IN_REQ   = 3'd4,
        ST_IN_WAIT  = 3'd5,
        ST_HALT     = 3'd6
    } sched_state_e;

endpackage

// File: rtl/usb_frame_timer.sv
// rtl/usb_frame_timer.sv - 1 ms frame counter with frame number, SOF tick and poll tick
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   run_i             count while high
//   clear_i           synchronous clear of all counters (wins over run_i)
//   frame_cnt_o       cycle position inside the current frame
//   frame_num_o       11-bit frame number, wraps at 2048
//   sof_tick_o        one-cycle pulse on the frame wrap edge
//   poll_tick_o       one-cycle pulse on every POLL_INTERVAL-th frame wrap

module usb_frame_timer #(
    parameter int FRAME_CYCLES  = 60000,
    parameter int POLL_INTERVAL = 10,
    parameter int CW            = $clog2(FRAME_CYCLES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run_i,
    input  logic          clear_i,
    output logic [CW-1:0] frame_cnt_o,
    output logic [10:0]   frame_num_o,
    output logic          sof_tick_o,
    output logic          poll_tick_o
);

    localparam logic [CW-1:0] LAST_CNT  = CW'(FRAME_CYCLES - 1);
    localparam logic [7:0]    POLL_LAST = 8'(POLL_INTERVAL - 1);

    logic [CW-1:0] cnt_q;
    logic [10:0]   fnum_q;
    logic [7:0]    poll_q;
    logic          wrap;

    assign wrap = run_i && !clear_i && (cnt_q == LAST_CNT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            fnum_q <= '0;
            poll_q <= '0;
        end else if (clear_i) begin
            cnt_q  <= '0;
            fnum_q <= '0;
            poll_q <= '0;
        end else if (run_i) begin
            if (wrap) begin
                cnt_q  <= '0;
                fnum_q <= fnum_q + 11'd1;
                poll_q <= (poll_q == POLL_LAST) ? 8'd0 : poll_q + 8'd1;
            end else begin
                cnt_q  <= cnt_q + CW'(1);
            end
        end
    end

    assign frame_cnt_o = cnt_q;
    assign frame_num_o = fnum_q;
    assign sof_tick_o  = wrap;
    assign poll_tick_o = wrap && (poll_q == POLL_LAST);

endmodule

// File: rtl/usb_poll_sched.sv
// rtl/usb_poll_sched.sv - SOF and interrupt-IN transaction scheduler for the HID host path
//
// Ports:
//   clk, rst                      60 MHz ULPI clock, asynchronous active-low reset
//   host_connect_i, enable_i      link up / enumeration complete; both needed to schedule
//   clear_halt_i                  pulse, leaves HALT
//   dev_addr_i, ep_i              target of the interrupt-IN polls
//   txn_req_o .. txn_toggle_o     request to the packet engine, held until txn_ack_i
//   frame_num_o                   current frame number
//   txn_ack_i, txn_done_i,
//   txn_result_i                  engine handshake and result
//   data_accept_o                 pulse, received report is new
//   halted_o, err_cnt_o           halt flag and consecutive error count

module usb_poll_sched
    import usb_sched_pkg::*;
#(
    parameter int FRAME_CYCLES  = 60000,
    parameter int POLL_INTERVAL = 10,
    parameter int GUARD_CYCLES  = 6000,
    parameter int MAX_RETRY     = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        host_connect_i,
    input  logic        enable_i,
    input  logic        clear_halt_i,
    input  logic [6:0]  dev_addr_i,
    input  logic [3:0]  ep_i,
    output logic        txn_req_o,
    output logic        txn_type_o,
    output logic [6:0]  txn_addr_o,
    output logic [3:0]  txn_ep_o,
    output logic        txn_toggle_o,
    output logic [10:0] frame_num_o,
    input  logic        txn_ack_i,
    input  logic        txn_done_i,
    input  logic [2:0]  txn_result_i,
    output logic        data_accept_o,
    output logic        halted_o,
    output logic [2:0]  err_cnt_o
);

    localparam int             CW       = $clog2(FRAME_CYCLES);
    localparam logic [CW-1:0]  IN_LIMIT = CW'(FRAME_CYCLES - GUARD_CYCLES);

    sched_state_e  state_q, state_d;
    logic          sof_pending_q, sof_pending_d;
    logic          poll_due_q, poll_due_d;
    logic          retry_block_q, retry_block_d;
    logic          toggle_q, toggle_d;
    logic [2:0]    err_cnt_q, err_cnt_d;
    logic          halted_q, halted_d;
    logic [6:0]    addr_q, addr_d;
    logic [3:0]    ep_q, ep_d;
    logic [2:0]    err_inc;

    logic          run;
    logic [CW-1:0] frame_cnt;
    logic          sof_tick;
    logic          poll_tick;

    assign run = host_connect_i && enable_i;

    usb_frame_timer #(
        .FRAME_CYCLES  (FRAME_CYCLES),
        .POLL_INTERVAL (POLL_INTERVAL),
        .CW            (CW)
    ) u_frame_timer (
        .clk         (clk),
        .rst         (rst),
        .run_i       (run),
        .clear_i     (!run),
        .frame_cnt_o (frame_cnt),
        .frame_num_o (frame_num_o),
        .sof_tick_o  (sof_tick),
        .poll_tick_o (poll_tick)
    );

    assign err_inc = (err_cnt_q == 3'd7) ? 3'd7 : err_cnt_q + 3'd1;

    always_comb begin
        state_d       = state_q;
        sof_pending_d = sof_pending_q;
        poll_due_d    = poll_due_q;
        retry_block_d = retry_block_q;
        toggle_d      = toggle_q;
        err_cnt_d     = err_cnt_q;
        halted_d      = halted_q;
        addr_d        = addr_q;
        ep_d          = ep_q;
        data_accept_o = 1'b0;

        case (state_q)
            ST_IDLE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (sof_pending_q) begin
                    state_d = ST_SOF_REQ;
                end else if (poll_due_q && !retry_block_q && (frame_cnt < IN_LIMIT)) begin
                    state_d = ST_IN_REQ;
                    addr_d  = dev_addr_i;
                    ep_d    = ep_i;
                end
            end
            ST_SOF_REQ: begin
                if (txn_ack_i) begin
                    state_d       = ST_SOF_WAIT;
                    sof_pending_d = 1'b0;
                end
            end
            ST_SOF_WAIT: begin
                // SOFs keep flowing while halted, so return to whichever idle state we came from.
                if (txn_done_i) state_d = halted_q ? ST_HALT : ST_WAIT;
            end
            ST_IN_REQ: begin
                if (txn_ack_i) state_d = ST_IN_WAIT;
            end
            ST_IN_WAIT: begin
                if (txn_done_i) begin
                    case (txn_result_i)
                        RES_DATA0, RES_DATA1: begin
                            // A PID that does not match the toggle is a retransmitted duplicate.
                            if (txn_result_i[0] == toggle_q) begin
                                data_accept_o = 1'b1;
                                toggle_d      = ~toggle_q;
                            end
                            err_cnt_d  = 3'd0;
                            poll_due_d = 1'b0;
                            state_d    = ST_WAIT;
                        end
                        RES_NAK: begin
                            err_cnt_d  = 3'd0;
                            poll_due_d = 1'b0;
                            state_d    = ST_WAIT;
                        end
                        RES_STALL: begin
                            halted_d = 1'b1;
                            state_d  = ST_HALT;
                        end
                        default: begin
                            err_cnt_d = err_inc;
                            if (err_inc >= 3'(MAX_RETRY)) begin
                                halted_d = 1'b1;
                                state_d  = ST_HALT;
                            end else begin
                                // poll_due stays set; the retry waits for the next frame.
                                retry_block_d = 1'b1;
                                state_d       = ST_WAIT;
                            end
                        end
                    endcase
                end
            end
            ST_HALT: begin
                if (clear_halt_i) begin
                    state_d    = ST_WAIT;
                    halted_d   = 1'b0;
                    toggle_d   = 1'b0;
                    err_cnt_d  = 3'd0;
                    poll_due_d = 1'b0;
                end else if (sof_pending_q) begin
                    state_d = ST_SOF_REQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Frame events are applied last so a wrap is never lost to a same-cycle clear.
        if (sof_tick) begin
            sof_pending_d = 1'b1;
            retry_block_d = 1'b0;
        end
        if (poll_tick && !halted_d) poll_due_d = 1'b1;

        if (!run) begin
            state_d       = ST_IDLE;
            sof_pending_d = 1'b0;
            poll_due_d    = 1'b0;
            retry_block_d = 1'b0;
            toggle_d      = 1'b0;
            err_cnt_d     = 3'd0;
            halted_d      = 1'b0;
            data_accept_o = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            sof_pending_q <= 1'b0;
            poll_due_q    <= 1'b0;
            retry_block_q <= 1'b0;
            toggle_q      <= 1'b0;
            err_cnt_q     <= 3'd0;
            halted_q      <= 1'b0;
            addr_q        <= 7'd0;
            ep_q          <= 4'd0;
        end else begin
            state_q       <= state_d;
            sof_pending_q <= sof_pending_d;
            poll_due_q    <= poll_due_d;
            retry_block_q <= retry_block_d;
            toggle_q      <= toggle_d;
            err_cnt_q     <= err_cnt_d;
            halted_q      <= halted_d;
            addr_q        <= addr_d;
            ep_q          <= ep_d;
        end
    end

    assign txn_req_o    = (state_q == ST_SOF_REQ) || (state_q == ST_IN_REQ);
    assign txn_type_o   = (state_q == ST_IN_REQ) ? TXN_IN : TXN_SOF;
    assign txn_addr_o   = (state_q == ST_IN_REQ) ? addr_q : 7'd0;
    assign txn_ep_o     = (state_q == ST_IN_REQ) ? ep_q : 4'd0;
    assign txn_toggle_o = toggle_q;
    assign halted_o     = halted_q;
    assign err_cnt_o    = err_cnt_q;

endmodule

// File: tb/tb_usb_poll_sched.sv
// tb/tb_usb_poll_sched.sv - scoreboard bench for usb_poll_sched

module tb_usb_poll_sched;

    logic        clk;
    logic        rst;
    logic        host_connect_i;
    logic        enable_i;
    logic        clear_halt_i;
    logic [6:0]  dev_addr_i;
    logic [3:0]  ep_i;
    logic        txn_req_o;
    logic        txn_type_o;
    logic [6:0]  txn_addr_o;
    logic [3:0]  txn_ep_o;
    logic        txn_toggle_o;
    logic [10:0] frame_num_o;
    logic        txn_ack_i;
    logic        txn_done_i;
    logic [2:0]  txn_result_i;
    logic        data_accept_o;
    logic        halted_o;
    logic [2:0]  err_cnt_o;

    int vectors    = 0;
    int miscompares = 0;

    typedef struct {
        logic        typ;
        logic        tog;
        logic [10:0] fnum;
        logic [2:0]  res;
        logic        acc;
        logic [2:0]  err;
        logic        halt;
    } exp_t;

    exp_t sb[$];

    usb_poll_sched #(
        .FRAME_CYCLES  (100),
        .POLL_INTERVAL (2),
        .GUARD_CYCLES  (10),
        .MAX_RETRY     (3)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .host_connect_i (host_connect_i),
        .enable_i       (enable_i),
        .clear_halt_i   (clear_halt_i),
        .dev_addr_i     (dev_addr_i),
        .ep_i           (ep_i),
        .txn_req_o      (txn_req_o),
        .txn_type_o     (txn_type_o),
        .txn_addr_o     (txn_addr_o),
        .txn_ep_o       (txn_ep_o),
        .txn_toggle_o   (txn_toggle_o),
        .frame_num_o    (frame_num_o),
        .txn_ack_i      (txn_ack_i),
        .txn_done_i     (txn_done_i),
        .txn_result_i   (txn_result_i),
        .data_accept_o  (data_accept_o),
        .halted_o       (halted_o),
        .err_cnt_o      (err_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

    task automatic push(input logic typ, input logic tog, input logic [10:0] fnum,
                        input logic [2:0] res, input logic acc, input logic [2:0] err,
                        input logic halt);
        exp_t e;
        e.typ = typ; e.tog = tog; e.fnum = fnum; e.res = res;
        e.acc = acc; e.err = err; e.halt = halt;
        sb.push_back(e);
    endtask

    // Plays the packet engine for the next expected transaction.
    task automatic serve(input int hold, output int waited);
        exp_t e;
        int   n;
        int   bad;
        e = sb.pop_front();
        n = 0;
        while (txn_req_o !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        waited = n;
        vectors++;
        if (txn_req_o !== 1'b1) begin
            $display("FAIL req_timeout: txn_req_o=%b after %0d cycles, want 1 (frame %0d)", txn_req_o, n, e.fnum);
            miscompares++;
            return;
        end
        vectors++;
        if (txn_type_o !== e.typ) begin
            $display("FAIL txn_type: got %b want %b (frame %0d)", txn_type_o, e.typ, e.fnum);
            miscompares++;
        end
        vectors++;
        if (frame_num_o !== e.fnum) begin
            $display("FAIL frame_num: got %0d want %0d", frame_num_o, e.fnum);
            miscompares++;
        end
        vectors++;
        if (txn_addr_o !== (e.typ ? dev_addr_i : 7'd0)) begin
            $display("FAIL txn_addr: got %h want %h (frame %0d)", txn_addr_o, e.typ ? dev_addr_i : 7'd0, e.fnum);
            miscompares++;
        end
        vectors++;
        if (txn_ep_o !== (e.typ ? ep_i : 4'd0)) begin
            $display("FAIL txn_ep: got %h want %h (frame %0d)", txn_ep_o, e.typ ? ep_i : 4'd0, e.fnum);
            miscompares++;
        end
        if (e.typ) begin
            vectors++;
            if (txn_toggle_o !== e.tog) begin
                $display("FAIL txn_toggle: got %b want %b (frame %0d)", txn_toggle_o, e.tog, e.fnum);
                miscompares++;
            end
        end
        txn_ack_i = 1'b1;
        @(negedge clk);
        txn_ack_i = 1'b0;
        vectors++;
        if (txn_req_o !== 1'b0) begin
            $display("FAIL req_drop: txn_req_o=%b after ack, want 0", txn_req_o);
            miscompares++;
        end
        bad = 0;
        repeat (hold) begin
            @(negedge clk);
            if (txn_req_o !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            $display("FAIL req_in_flight: %0d cycles with txn_req_o=1 while awaiting done, want 0", bad);
            miscompares++;
        end
        txn_result_i = e.res;
        txn_done_i   = 1'b1;
        #1;
        vectors++;
        if (data_accept_o !== e.acc) begin
            $display("FAIL data_accept: got %b want %b (frame %0d result %0d)", data_accept_o, e.acc, e.fnum, e.res);
            miscompares++;
        end
        @(negedge clk);
        txn_done_i   = 1'b0;
        txn_result_i = 3'd0;
        vectors++;
        if (err_cnt_o !== e.err) begin
            $display("FAIL err_cnt: got %0d want %0d (frame %0d)", err_cnt_o, e.err, e.fnum);
            miscompares++;
        end
        vectors++;
        if (halted_o !== e.halt) begin
            $display("FAIL halted: got %b want %b (frame %0d)", halted_o, e.halt, e.fnum);
            miscompares++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        host_connect_i = 1'b0; enable_i = 1'b0; clear_halt_i = 1'b0;
        dev_addr_i = 7'h2A; ep_i = 4'h3;
        txn_ack_i = 1'b0; txn_done_i = 1'b0; txn_result_i = 3'd0;
        repeat (3) @(negedge clk);
        vectors++; if (txn_req_o !== 1'b0)     begin $display("FAIL rst_req: got %b want 0", txn_req_o); miscompares++; end
        vectors++; if (txn_type_o !== 1'b0)    begin $display("FAIL rst_type: got %b want 0", txn_type_o); miscompares++; end
        vectors++; if (txn_addr_o !== 7'd0)    begin $display("FAIL rst_addr: got %h want 0", txn_addr_o); miscompares++; end
        vectors++; if (txn_ep_o !== 4'd0)      begin $display("FAIL rst_ep: got %h want 0", txn_ep_o); miscompares++; end
        vectors++; if (txn_toggle_o !== 1'b0)  begin $display("FAIL rst_toggle: got %b want 0", txn_toggle_o); miscompares++; end
        vectors++; if (frame_num_o !== 11'd0)  begin $display("FAIL rst_frame: got %0d want 0", frame_num_o); miscompares++; end
        vectors++; if (data_accept_o !== 1'b0) begin $display("FAIL rst_accept: got %b want 0", data_accept_o); miscompares++; end
        vectors++; if (halted_o !== 1'b0)      begin $display("FAIL rst_halted: got %b want 0", halted_o); miscompares++; end
        vectors++; if (err_cnt_o !== 3'd0)     begin $display("FAIL rst_err: got %0d want 0", err_cnt_o); miscompares++; end
        rst = 1'b1;
        repeat (150) @(negedge clk);
        vectors++; if (txn_req_o !== 1'b0)     begin $display("FAIL idle_req: got %b want 0 while disconnected", txn_req_o); miscompares++; end
        vectors++; if (frame_num_o !== 11'd0)  begin $display("FAIL idle_frame: got %0d want 0 while disconnected", frame_num_o); miscompares++; end
    endtask

    // Frames 1..8: SOF each frame, IN every 2nd; results DATA0, DATA1, DATA1 (dup), DATA0.
    task automatic test_sof_and_toggle();
        int w;
        host_connect_i = 1'b1;
        enable_i       = 1'b1;
        push(1'b0, 1'b0, 11'd1, 3'd0, 1'b0, 3'd0, 1'b0);
        push(1'b0, 1'b0, 11'd2, 3'd0, 1'b0, 3'd0, 1'b0);
        push(1'b1, 1'b0, 11'd2, 3'd0, 1'b1, 3'd0, 1'b0);
        push(1'b0, 1'b0, 11'd3, 3'd1, 1'b0, 3'd0, 1'b0);
        push(1'b0, 1'b0, 11'd4, 3'd0, 1'b0, 3'd0, 1'b0);
        push(1'b1, 1'b1, 11'd4, 3'd1, 1'b1, 3'd0, 1'b0);
        push(1'b0, 1'b0, 11'd5, 3'd0, 1'b0, 3'd0, 1'b0);
        push(1'b0, 1'b0, 11'd6, 3'd0, 1'b0, 3'd0, 1'b0);
        push(1'b1, 1'b0, 11'd6, 3'd1, 1'b0, 3'd0, 1'b0);
        push(1'b0, 1'b0, 11'd7, 3'd0, 1'b0, 3'd0, 1'b0);
        push(1'b0, 1'b0, 11'd8, 3'd0, 1'b0, 3'd0, 1'b0);
        push(1'b1, 1'b0, 11'd8, 3'd0, 1'b1, 3'd0, 1'b0);
        while (sb.size() > 0) serve(2, w);
    endtask

    // TIMEOUT, CRC_ERR, undefined code in three consecutive frames, then halt and clear.
    task automatic test_timeout_halt();
        int w;
        push(1'b0, 1'b1, 11'd9,  3'd0, 1'b0, 3'd0, 1'b0);
        push(1'b0, 1'b1, 11'd10, 3'd0, 1'b0, 3'd0, 1'b0);
        push(1'b1, 1'b1, 11'd10, 3'd4, 1'b0, 3'd1, 1'b0);
        push(1'b0, 1'b1, 11'd11, 3'd0, 1'b0, 3'd1, 1'b0);
        push(1'b1, 1'b1, 11'd11, 3'd5, 1'b0, 3'd2, 1'b0);
        push(1'b0, 1'b1, 11'd12, 3'd0, 1'b0, 3'd2, 1'b0);
        push(1'b1, 1'b1, 11'd12, 3'd6, 1'b0, 3'd3, 1'b1);
        push(1'b0, 1'b1, 11'd13, 3'd0, 1'b0, 3'd3, 1'b1);
        push(1'b0, 1'b1, 11'd14, 3'd0, 1'b0, 3'd3, 1'b1);
        while (sb.size() > 0) serve(2, w);
        clear_halt_i = 1'b1;
        @(negedge clk);
        clear_halt_i = 1'b0;
        vectors++; if (halted_o !== 1'b0)     begin $display("FAIL clear_halted: got %b want 0", halted_o); miscompares++; end
        vectors++; if (err_cnt_o !== 3'd0)    begin $display("FAIL clear_err: got %0d want 0", err_cnt_o); miscompares++; end
        vectors++; if (txn_toggle_o !== 1'b0) begin $display("FAIL clear_toggle: got %b want 0", txn_toggle_o); miscompares++; end
        push(1'b0, 1'b0, 11'd15, 3'd0, 1'b0, 3'd0, 1'b0);
        push(1'b0, 1'b0, 11'd16, 3'd0, 1'b0, 3'd0, 1'b0);
        push(1'b1, 1'b0, 11'd16, 3'd0, 1'b1, 3'd0, 1'b0);
        while (sb.size() > 0) serve(2, w);
    endtask

    // Done withheld across the frame boundary; the SOF must follow the IN immediately.
    task automatic test_wrap_in_wait();
        int w;
        push(1'b0, 1'b1, 11'd17, 3'd0, 1'b0, 3'd0, 1'b0);
        push(1'b0, 1'b1, 11'd18, 3'd0, 1'b0, 3'd0, 1'b0);
        push(1'b1, 1'b1, 11'd18, 3'd2, 1'b0, 3'd0, 1'b0);
        serve(2, w);
        serve(2, w);
        serve(110, w);
        push(1'b0, 1'b1, 11'd19, 3'd0, 1'b0, 3'd0, 1'b0);
        serve(2, w);
        vectors++;
        if (w > 2) begin
            $display("FAIL sof_after_in: SOF came %0d cycles after done, want <= 2", w);
            miscompares++;
        end
    endtask

    task automatic test_disconnect();
        int w;
        int n;
        push(1'b0, 1'b1, 11'd20, 3'd0, 1'b0, 3'd0, 1'b0);
        serve(2, w);
        n = 0;
        while (txn_req_o !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (txn_req_o !== 1'b1 || txn_type_o !== 1'b1) begin
            $display("FAIL in_before_drop: req=%b type=%b, want req=1 type=1", txn_req_o, txn_type_o);
            miscompares++;
        end
        host_connect_i = 1'b0;
        @(negedge clk);
        vectors++; if (txn_req_o !== 1'b0)     begin $display("FAIL drop_req: got %b want 0", txn_req_o); miscompares++; end
        vectors++; if (frame_num_o !== 11'd0)  begin $display("FAIL drop_frame: got %0d want 0", frame_num_o); miscompares++; end
        vectors++; if (txn_toggle_o !== 1'b0)  begin $display("FAIL drop_toggle: got %b want 0", txn_toggle_o); miscompares++; end
        vectors++; if (halted_o !== 1'b0)      begin $display("FAIL drop_halted: got %b want 0", halted_o); miscompares++; end
        host_connect_i = 1'b1;
        push(1'b0, 1'b0, 11'd1, 3'd0, 1'b0, 3'd0, 1'b0);
        serve(2, w);
        vectors++;
        if (w < 100 || w > 102) begin
            $display("FAIL reconnect_sof: first SOF after %0d cycles, want 100..102", w);
            miscompares++;
        end
    endtask

    initial begin
        test_reset();
        test_sof_and_toggle();
        test_timeout_halt();
        test_wrap_in_wait();
        test_disconnect();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/usb_poll_sched.md
Name: usb_poll_sched

Overview:
Transaction scheduler for the ULPI HID host path. It keeps the 1 ms full-speed frame timer and issues one SOF request per frame. Every POLL_INTERVAL frames it issues an interrupt-IN request to the packet engine, tracks the DATA0/DATA1 toggle, and retries on error or halts. It sits between the link/connect logic and the packet engine, and it gates when report data may be accepted downstream.

Parameters:
FRAME_CYCLES, 60000, clk cycles per frame (60 MHz ULPI clock).
POLL_INTERVAL, 10, frames between IN polls (bInterval); must be 1..255.
GUARD_CYCLES, 6000, an IN request is not started if fewer than this many cycles remain in the frame.
MAX_RETRY, 3, consecutive TIMEOUT/CRC errors allowed before HALT; must be 1..7.

Ports:
clk  in  1  ULPI 60 MHz clock; the only clock.
rst  in  1  reset; asynchronous, active-low (0 = reset).
host_connect_i  in  1  device attached and link up.
enable_i  in  1  scheduling enable (enumeration complete).
clear_halt_i  in  1  one-cycle pulse; leaves HALT.
dev_addr_i  in  7  target device address.
ep_i  in  4  interrupt-IN endpoint number.
txn_req_o  out  1  transaction request; held until accepted.
txn_type_o  out  1  0 = SOF, 1 = IN.
txn_addr_o  out  7  address field (IN only; 0 for SOF).
txn_ep_o  out  4  endpoint field (IN only; 0 for SOF).
txn_toggle_o  out  1  expected data PID (0 = DATA0).
frame_num_o  out  11  current frame number.
txn_ack_i  in  1  engine accepted the request.
txn_done_i  in  1  one-cycle pulse; transaction finished.
txn_result_i  in  3  0 DATA0, 1 DATA1, 2 NAK, 3 STALL, 4 TIMEOUT, 5 CRC_ERR; valid with done.
data_accept_o  out  1  one-cycle pulse; the received report is new and must be latched.
halted_o  out  1  in HALT.
err_cnt_o  out  3  consecutive error count.

Behaviour:
- Reset: all outputs 0; state IDLE; frame counter 0; toggle 0; poll counter 0.
- Frame timer: runs only when host_connect_i && enable_i.
  - Counts 0..FRAME_CYCLES-1. On wrap: frame_num +1 mod 2048, sof_pending set, poll counter +1.
  - When the poll counter reaches POLL_INTERVAL it resets to 0 and poll_due is set.
- States:
  - IDLE → WAIT when connected and enabled.
  - WAIT: if sof_pending → SOF_REQ. Else if poll_due && frame_cnt < FRAME_CYCLES-GUARD_CYCLES → IN_REQ.
  - SOF_REQ: txn_req_o=1, type 0. On txn_ack_i → SOF_WAIT; clear sof_pending.
  - SOF_WAIT: on txn_done_i → WAIT; the result is ignored.
  - IN_REQ: txn_req_o=1, type 1, fields = dev_addr_i/ep_i/toggle. Fields are captured on entry and stable until ack. On ack → IN_WAIT.
  - IN_WAIT: on txn_done_i, decode the result as follows.
    - DATA matching toggle: data_accept_o=1 that cycle; toggle flips; err_cnt=0; poll_due cleared; → WAIT.
    - DATA with wrong toggle: duplicate; no accept pulse; toggle unchanged; err_cnt=0; poll_due cleared.
    - NAK: poll_due cleared; err_cnt=0; → WAIT.
    - TIMEOUT/CRC_ERR: err_cnt+1. If it reaches MAX_RETRY → HALT. Else poll_due stays set and the retry happens in the next frame, not the current one.
    - STALL → HALT.
    - Undefined codes (6, 7) are treated as TIMEOUT.
  - HALT: halted_o=1; no IN requests; SOFs continue.
    - clear_halt_i → WAIT with toggle=0, err_cnt=0, poll_due=0.
- Handshake: txn_req_o is asserted only in *_REQ states and dropped the cycle after ack. txn_done_i is ignored outside *_WAIT.
- Frame wrap during IN_WAIT or IN_REQ: sof_pending latches and the SOF goes out after the IN completes. SOF has priority over a due IN in WAIT.
- poll_due arriving while in HALT is discarded.
- Disconnect or enable_i=0 in any state, including mid-handshake:
  - Next cycle → IDLE; txn_req_o=0.
  - Clear frame counter, frame_num, poll counter, toggle, err_cnt, sof_pending, poll_due, halted_o.
- Counter widths: frame counter $clog2(FRAME_CYCLES); poll counter 8 bits; err_cnt saturates at 7.

Decomposition:
- Package usb_sched_pkg: txn_type_e, txn_result_e (3-bit codes above), sched_state_e.
- Sub-module usb_frame_timer: frame counter, frame_num, sof tick, poll_due tick; inputs run/clear.

Test Plan:
- Reset: rst=0 then 1 with host_connect_i=0 → every output 0 and no txn_req_o.
- FRAME_CYCLES=100, POLL_INTERVAL=2, connect+enable, ack/done after 3 cycles → SOF requests every 100 cycles, frame_num 1,2,3…; IN request every 2nd frame after its SOF, addr/ep match inputs.
- IN results DATA0, DATA1, DATA1 → accept pulses on the 1st and 2nd only; txn_toggle_o goes 0,1,0; third counted as duplicate.
- Three consecutive TIMEOUTs with MAX_RETRY=3 → one retry per frame, err_cnt 1,2,3, halted_o=1; SOFs continue; clear_halt_i → next IN uses toggle 0.
- Frame wrap while done is withheld in IN_WAIT → SOF issued right after done; frame_num incremented exactly once.
- host_connect_i dropped during IN_REQ → txn_req_o low next cycle, frame_num=0, toggle=0; reconnect → first SOF after FRAME_CYCLES cycles.
